vrf_write_arbiter: RTL
======================

# vrf_write_arbiter

Write-port controller for the 8-entry, 32-bit vector register file. It shares the register file's single write port between NUM_REQ writeback requesters (ALU lanes, load unit, host preload) using round-robin arbitration with optional burst locking. It registers the winning beat and drives write_enable / write_addr / write_data of the register file one cycle later. It sits between the execute/writeback stage and the register file.

## Interface
- NUM_REQ, 3, number of write requesters (2..4)
- ADDR_W, 3, register address width
- DATA_W, 32, register data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  sequencer stall; blocks new grants
- req_valid  in  NUM_REQ  per-requester write beat valid
- req_lock  in  NUM_REQ  keep the port after this beat
- req_addr  in  NUM_REQ*ADDR_W  packed target register, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- rf_write_enable  out  1  register-file write strobe
- rf_write_addr  out  ADDR_W  register-file write address
- rf_write_data  out  DATA_W  register-file write data
- grant_id  out  2  index of the requester owning the current/last grant
- locked  out  1  port held by grant_id

## Operation
- States: ARB, LOCK.
- ARB, freeze=0:
  - Winner is the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is asserted combinationally for the winner only.
- A beat is accepted when req_valid[i] & req_ready[i]. Its addr/data is captured into the output stage and grant_id becomes i.
- Accepted beat with req_lock=1: go to LOCK on i. Otherwise stay in ARB, and rr_ptr becomes (i+1) mod NUM_REQ.
- LOCK:
  - req_ready is asserted only for grant_id, when freeze=0. All other requesters see ready=0.
  - The lock is held even while req_valid[grant_id]=0. The port idles and no other grant is given.
  - An accepted beat with req_lock=0 returns to ARB, and rr_ptr becomes grant_id+1.
- freeze=1: all req_ready=0. The output stage still writes its captured beat. State, rr_ptr and lock are retained.
- No valid request: output stage empty, rf_write_enable=0 next cycle, rr_ptr unchanged.
- Two requesters targeting the same register in the same cycle: only the winner is accepted. The loser keeps its beat pending.
- locked = (state==LOCK).

## Timing
- Reset values: rf_write_enable=0, rf_write_addr=0, rf_write_data=0, grant_id=0, locked=0, rr_ptr=0, state ARB. req_ready follows the combinational rule with reset state.
- Latency: a beat accepted at edge N drives rf_write_enable=1 in the cycle after edge N. The register file commits it at edge N+1.
- Throughput: one beat per cycle, no bubbles between back-to-back grants, including a grant switch.
- rf_write_enable is high for exactly one cycle per accepted beat.
- rst_n asserted mid-burst: the lock is released, and any captured beat is discarded without a write.

## Configuration
- VRF_ARB_R0_DROP_EN defined:
  - Beats addressed to register 0 are accepted normally: handshake, arbitration and lock updates all apply.
  - rf_write_enable stays 0 for them, so r0 reads as hardwired zero.
- Not defined: register 0 is written like any other register.

## Structure
- A shared package holds ADDR_W/DATA_W defaults, the ARB/LOCK state encoding, and the requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_HOST=2).
- One sub-module, rr_picker: combinational round-robin first-one-from-pointer select. It returns a one-hot grant and an index. Everything else lives in the top module.

## Test plan
- Reset then idle:
  - rst_n low → all outputs 0, state ARB.
  - Release with no valid → rf_write_enable stays 0.
- Round-robin:
  - Stimulus: requesters 0,1,2 all valid continuously with addr 1,2,3 and data 0x11111111 / 0x22222222 / 0x33333333.
  - Required: writes in order 0,1,2,0,… one per cycle, each one cycle after its ready.
- Lock burst:
  - Stimulus: requester 1 sends 3 beats (lock=1,1,0) to addr 4,5,6 while requester 0 stays valid.
  - Required: req_ready[0]=0 throughout. Requester 0 is granted on the cycle after the lock=0 beat.
- Lock with gap: requester 2 locked, then drops valid for 2 cycles → no grants to others, locked=1, rf_write_enable=0 during the gap.
- Freeze: freeze=1 for 3 cycles with all valid → no req_ready. The beat captured before freeze is still written. Arbitration resumes at rr_ptr.
- Macro and reset:
  - With VRF_ARB_R0_DROP_EN, a write of 0xA5A5A5A5 to addr 0 → accepted, rf_write_enable stays 0.
  - rst_n pulsed mid-lock → locked=0, the captured beat is not written.

Source files
------------

// File: rtl/vrf_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vrf_write_arbiter_pkg                                      |
// | Description : Shared definitions for the vector register file write-port |
// |               arbiter: width defaults, the ARB/LOCK state encoding,      |
// |               requester index constants and the pointer-wrap helper.     |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package vrf_write_arbiter_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 32;

  // Requester indices and grant_id are always two bits wide (up to 4 requesters).
  localparam int IDX_W = 2;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_HOST = 2;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage : vrf_write_arbiter_pkg
`default_nettype wire

// File: rtl/vrf_write_arbiter_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_picker                                                  |
// | Description : Combinational round-robin select: first asserted request   |
// |               at or after ptr, wrapping modulo NUM_REQ.                  |
// | Ports       : req[NUM_REQ]   - request vector                            |
// |               ptr            - highest-priority index (< NUM_REQ)        |
// |               grant[NUM_REQ] - one-hot winner (zero when no request)     |
// |               grant_idx      - binary index of winner                    |
// |               grant_valid    - a winner exists                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_picker
  import vrf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin : p_pick
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    cand        = '0;
    // Walk candidates in priority order ptr, ptr+1, ... and keep the first hit.
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/vrf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vrf_write_arbiter                                          |
// | Description : Shares the single write port of the 8x32 vector register   |
// |               file between NUM_REQ writeback requesters. Round-robin     |
// |               arbitration with burst locking; the winning beat is        |
// |               registered and presented to the register file one cycle   |
// |               after acceptance.                                          |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               freeze          - stall, blocks all grants                 |
// |               req_valid/lock  - per-requester beat valid / keep port     |
// |               req_addr/data   - packed per-requester address / data      |
// |               req_ready       - per-requester accept (one-hot or zero)   |
// |               rf_write_*      - register-file write port                 |
// |               grant_id/locked - current owner / burst lock held          |
// | Options     : VRF_ARB_R0_DROP_EN - beats to register 0 are accepted but  |
// |               never strobe rf_write_enable (r0 reads as zero).           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vrf_write_arbiter
  import vrf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      freeze,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      locked
);

  arb_state_e         state_q,    state_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic               wen_q,      wen_d;
  logic [ADDR_W-1:0]  waddr_q,    waddr_d;
  logic [DATA_W-1:0]  wdata_q,    wdata_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic [NUM_REQ-1:0] lock_oh;
  logic               accept;
  logic [IDX_W-1:0]   acc_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_lock;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (pick_grant),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // One-hot view of the lock owner.
  always_comb begin
    lock_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lock_oh[i] = (grant_id_q == IDX_W'(i));
    end
  end

  // Handshake: in LOCK the owner sees ready even while it has no beat, so the
  // port idles rather than being handed to someone else.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    acc_idx   = grant_id_q;
    if (!freeze) begin
      case (state_q)
        ST_LOCK: begin
          req_ready = lock_oh;
          accept    = |(req_valid & lock_oh);
        end
        default: begin
          req_ready = pick_grant;
          accept    = pick_valid;
          acc_idx   = pick_idx;
        end
      endcase
    end
  end

  // Route the accepted requester's beat.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_lock = req_lock[i];
      end
    end
  end

  // Next state / output stage. Without an accepted beat only the strobe drops;
  // address and data hold the last captured beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (accept) begin
`ifdef VRF_ARB_R0_DROP_EN
      wen_d = (sel_addr != '0);
`else
      wen_d = 1'b1;
`endif
      waddr_d    = sel_addr;
      wdata_d    = sel_data;
      grant_id_d = acc_idx;
      if (sel_lock) begin
        state_d = ST_LOCK;
      end else begin
        state_d  = ST_ARB;
        rr_ptr_d = wrap_inc(acc_idx, NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign rf_write_enable = wen_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  assign grant_id        = grant_id_q;
  assign locked          = (state_q == ST_LOCK);

endmodule : vrf_write_arbiter
`default_nettype wire
